serial_parity_framer: RTL
=========================

Name: serial_parity_framer

Overview:
- Accepts a parallel data word over a valid/ready handshake and serialises it LSB-first on a one-bit stream.
- Appends one parity bit after the data bits.
- The running parity is accumulated one bit per clock through an instance of the team's cmos_xor_xnor cell, so this block consumes that cell's output.
- Sits between the word-level datapath and the serial line driver.

Parameters:
- DATA_W, 8, data word width in bits; legal range 2..32.
- ODD_PARITY, 0, 0 = even parity (data ones + parity bit is even); 1 = odd parity.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
- in_data  input  DATA_W  word to transmit.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word this cycle.
- ser_o  output  1  serial bit (data LSB-first, then parity).
- ser_valid  output  1  ser_o carries a frame bit this cycle.
- sof  output  1  high on the first data bit of a frame.
- eof  output  1  high on the parity bit of a frame.
- busy  output  1  frame in progress (state is not IDLE).

Behaviour:
- Reset (rst_n low at a rising edge):
  - state = IDLE, shift register = 0, bit counter = 0, parity register = ODD_PARITY.
  - Outputs while in reset/IDLE: in_ready = 1, ser_o = 0, ser_valid = 0, sof = 0, eof = 0, busy = 0.
  - Reset mid-frame aborts the frame immediately; the partial frame is never completed or re-sent.
- States: IDLE, SHIFT, PARITY. All outputs decode from registered state only; no combinational path from inputs to outputs.
- Handshake:
  - Transfer occurs when in_valid && in_ready at a rising edge.
  - in_ready = 1 in IDLE and PARITY, 0 in SHIFT.
  - in_data is ignored when not transferred.
  - in_valid high while in_ready is low is not an error; the word is held off.
- On transfer:
  - Shift register <= in_data; bit counter <= 0; parity register <= ODD_PARITY; state <= SHIFT.
- SHIFT (DATA_W cycles):
  - ser_o = shift register bit 0; ser_valid = 1; sof = 1 only when counter == 0.
  - Each edge: parity register <= xor_o of the cmos_xor_xnor instance (a = parity register, b = shift register bit 0).
  - Each edge: shift register shifts right by one, zero-fill; counter increments.
  - When counter == DATA_W-1, the next state is PARITY.
- PARITY (1 cycle):
  - ser_o = parity register; ser_valid = 1; eof = 1.
  - With a transfer this cycle: next state SHIFT, reload as above, giving back-to-back frames with no gap.
  - Without a transfer: next state IDLE.
- Latency and throughput:
  - The first data bit appears on the cycle after the accepting edge.
  - A frame is DATA_W+1 cycles.
  - Sustained throughput is one word per DATA_W+1 cycles.
- Counter width is clog2(DATA_W); it never wraps past DATA_W-1.
- The xnor_o output of the cell is left unconnected.

Test Plan:
- Reset behaviour, DATA_W=8, ODD_PARITY=0: hold rst_n low for 3 cycles, then release with in_valid=0 -> in_ready=1, ser_valid=0, busy=0 on every cycle.
- Even parity, word 0xA5: send 0xA5 -> ser_o sequence 1,0,1,0,0,1,0,1 then parity 0. sof is on bit 0 only, eof is on the 9th cycle, in_ready=0 for the 8 data cycles.
- Even parity, word 0x07: send 0x07 -> bits 1,1,1,0,0,0,0,0, parity 1.
- Odd parity, ODD_PARITY=1: send 0xA5 -> parity bit 1; send 0x00 -> parity bit 1.
- Back-to-back frames: hold in_valid=1 and present 0x3C then 0xFF. The second word is accepted in the eof cycle of the first. ser_valid stays 1 for 18 consecutive cycles with no IDLE gap. Parities are 0 and 0 (even).
- Reset mid-frame: assert rst_n low during the 4th data bit of 0xA5 -> the next cycle shows IDLE outputs. After release, a fresh send of 0x01 produces bits 1,0,0,0,0,0,0,0 and parity 1, with no residue from the aborted frame.

Source files
------------

// File: rtl/serial_parity_framer.sv
// Word-to-serial framer: LSB-first data bits followed by one parity bit,
// with parity accumulated bit-serially through the cmos_xor_xnor cell.

module cmos_xor_xnor (
  input  logic a,
  input  logic b,
  output logic xor_o,
  output logic xnor_o
);
  assign xor_o  = a ^ b;
  assign xnor_o = ~(a ^ b);
endmodule

module serial_parity_framer #(
  parameter int DATA_W     = 8,
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ser_o,
  output logic              ser_valid,
  output logic              sof,
  output logic              eof,
  output logic              busy
);
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;

  state_t             state_q;
  logic [DATA_W-1:0]  shift_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               parity_q;
  logic               parity_d;
  logic               accept;
  logic               last_bit;

  cmos_xor_xnor u_parity_cell (
    .a      (parity_q),
    .b      (shift_q[0]),
    .xor_o  (parity_d),
    .xnor_o ()
  );

  assign accept   = in_valid && in_ready;
  assign last_bit = (cnt_q == CNT_W'(DATA_W - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      cnt_q    <= '0;
      parity_q <= ODD_PARITY;
    end else begin
      case (state_q)
        SHIFT: begin
          parity_q <= parity_d;
          shift_q  <= shift_q >> 1;
          if (last_bit) begin
            state_q <= PARITY;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        IDLE, PARITY: begin
          // A word offered during the parity bit starts the next frame with no gap.
          if (accept) begin
            state_q  <= SHIFT;
            shift_q  <= in_data;
            cnt_q    <= '0;
            parity_q <= ODD_PARITY;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q != SHIFT);
  assign ser_valid = (state_q == SHIFT) || (state_q == PARITY);
  assign ser_o     = (state_q == SHIFT)  ? shift_q[0] :
                     (state_q == PARITY) ? parity_q   : 1'b0;
  assign sof       = (state_q == SHIFT) && (cnt_q == '0);
  assign eof       = (state_q == PARITY);
  assign busy      = (state_q != IDLE);

endmodule
